// File: rtl/debug_override_entry_pkg.sv
// Shared constants for the debug override entry block: field codes, FSM states, KEY indices.
package debug_override_entry_pkg;

    // Field select codes on SW[8:7]
    localparam logic [1:0] FLD_SPEED = 2'b00;
    localparam logic [1:0] FLD_DIR   = 2'b01;
    localparam logic [1:0] FLD_REV   = 2'b10;
    localparam logic [1:0] FLD_CLEAR = 2'b11;

    // Pushbutton indices; KEY[3] is reserved for challenge select
    localparam int unsigned KEY_CANCEL = 0;
    localparam int unsigned KEY_SHIFT  = 1;
    localparam int unsigned KEY_COMMIT = 2;

    localparam int unsigned AccW = 9;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StEntry  = 2'b01,
        StCommit = 2'b10
    } state_e;

    // Shift a new nibble into the accumulator; upper bits fall off the 9-bit word
    function automatic logic [AccW-1:0] shift_nibble(input logic [AccW-1:0] acc,
                                                     input logic [3:0]      nib);
        return {acc[4:0], nib};
    endfunction

endpackage

// File: rtl/debug_override_entry_if.sv
// Operator I/O bundle: switch/key inputs and override/status outputs.
interface debug_override_entry_if;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [6:0] override_speed;
    logic       override_speed_en;
    logic [8:0] override_dir;
    logic       override_dir_en;
    logic       override_reverse;
    logic       override_rev_en;
    logic [8:0] entry_value;
    logic       entry_active;
    logic       commit_ok;
    logic       commit_reject;

    // Operator / board side
    modport master (
        output SW, KEY,
        input  override_speed, override_speed_en, override_dir, override_dir_en,
        input  override_reverse, override_rev_en, entry_value, entry_active,
        input  commit_ok, commit_reject
    );

    // Entry block side
    modport slave (
        input  SW, KEY,
        output override_speed, override_speed_en, override_dir, override_dir_en,
        output override_reverse, override_rev_en, entry_value, entry_active,
        output commit_ok, commit_reject
    );
endinterface

// File: rtl/debug_override_entry_key_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse.
module debug_override_entry_key_debouncer #(
    parameter int unsigned DebounceTicks = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,    // raw, active-low
    output logic press_o   // one cycle on accepted 1->0 transition
);

    localparam int unsigned CntW = (DebounceTicks > 1) ? $clog2(DebounceTicks) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    // Accept a new level only after it has differed from the debounced level for DebounceTicks
    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CntLast) begin
                db_d    = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer and debounce state; released (high) out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/debug_override_entry.sv
// Operator override entry: debounced keys drive a nibble-entry FSM that commits
// speed / direction / reverse overrides with range checking.
module debug_override_entry
    import debug_override_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 500000,
    parameter int unsigned TIMEOUT_TICKS  = 500000000,
    parameter int unsigned SPEED_MAX      = 100,
    parameter int unsigned DIR_MAX        = 359
) (
    input  logic                         CLOCK_50,
    input  logic                         async_reset,
    debug_override_entry_if.slave        bus
);

    localparam int unsigned TmoW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT_TICKS - 1);
    localparam logic [AccW-1:0] SpeedMaxV = AccW'(SPEED_MAX);
    localparam logic [AccW-1:0] DirMaxV   = AccW'(DIR_MAX);

    logic [2:0] ev;
    logic       do_cancel, do_commit, do_shift;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [6:0]      speed_q, speed_d;
    logic            speed_en_q, speed_en_d;
    logic [8:0]      dir_q, dir_d;
    logic            dir_en_q, dir_en_d;
    logic            rev_q, rev_d;
    logic            rev_en_q, rev_en_d;
    logic            ok_q, ok_d;
    logic            rej_q, rej_d;

    // SW[6:4] and KEY[3] are not used by this block
    logic [3:0] unused_bits;
    assign unused_bits = {bus.SW[6:4], bus.KEY[3]};

    for (genvar k = 0; k < 3; k++) begin : g_key
        debug_override_entry_key_debouncer #(
            .DebounceTicks(DEBOUNCE_TICKS)
        ) u_db (
            .clk_i  (CLOCK_50),
            .rst_ni (async_reset),
            .key_i  (bus.KEY[k]),
            .press_o(ev[k])
        );
    end

    // Same-cycle priority: cancel > commit > shift; losers are dropped
    assign do_cancel = ev[KEY_CANCEL];
    assign do_commit = ev[KEY_COMMIT] & ~ev[KEY_CANCEL];
    assign do_shift  = ev[KEY_SHIFT] & ~ev[KEY_COMMIT] & ~ev[KEY_CANCEL];

    // Entry FSM, accumulator, idle timeout and override updates
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tmo_d      = '0;
        speed_d    = speed_q;
        speed_en_d = speed_en_q;
        dir_d      = dir_q;
        dir_en_d   = dir_en_q;
        rev_d      = rev_q;
        rev_en_d   = rev_en_q;
        ok_d       = 1'b0;
        rej_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (do_cancel) begin
                    speed_en_d = 1'b0;
                    dir_en_d   = 1'b0;
                    rev_en_d   = 1'b0;
                end else if (do_shift && bus.SW[9]) begin
                    state_d = StEntry;
                    acc_d   = {5'b0, bus.SW[3:0]};
                end
            end
            StEntry: begin
                if (do_cancel || !bus.SW[9]) begin
                    state_d = StIdle;
                    acc_d   = '0;
                end else if (do_commit) begin
                    state_d = StCommit;
                end else if (do_shift) begin
                    acc_d = shift_nibble(acc_q, bus.SW[3:0]);
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                    acc_d   = '0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StCommit: begin
                state_d = StIdle;
                acc_d   = '0;
                unique case (bus.SW[8:7])
                    FLD_SPEED: begin
                        if (acc_q <= SpeedMaxV) begin
                            speed_d    = acc_q[6:0];
                            speed_en_d = 1'b1;
                            ok_d       = 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                    FLD_DIR: begin
                        if (acc_q <= DirMaxV) begin
                            dir_d    = acc_q;
                            dir_en_d = 1'b1;
                            ok_d     = 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                    FLD_REV: begin
                        rev_d    = acc_q[0];
                        rev_en_d = 1'b1;
                        ok_d     = 1'b1;
                    end
                    FLD_CLEAR: begin
                        speed_en_d = 1'b0;
                        dir_en_d   = 1'b0;
                        rev_en_d   = 1'b0;
                        ok_d       = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
            end
        endcase
    end

    // State and override registers; everything returns to zero on reset
    always_ff @(posedge CLOCK_50 or negedge async_reset) begin
        if (!async_reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            tmo_q      <= '0;
            speed_q    <= '0;
            speed_en_q <= 1'b0;
            dir_q      <= '0;
            dir_en_q   <= 1'b0;
            rev_q      <= 1'b0;
            rev_en_q   <= 1'b0;
            ok_q       <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            speed_q    <= speed_d;
            speed_en_q <= speed_en_d;
            dir_q      <= dir_d;
            dir_en_q   <= dir_en_d;
            rev_q      <= rev_d;
            rev_en_q   <= rev_en_d;
            ok_q       <= ok_d;
            rej_q      <= rej_d;
        end
    end

    assign bus.override_speed    = speed_q;
    assign bus.override_speed_en = speed_en_q;
    assign bus.override_dir      = dir_q;
    assign bus.override_dir_en   = dir_en_q;
    assign bus.override_reverse  = rev_q;
    assign bus.override_rev_en   = rev_en_q;
    assign bus.entry_value       = acc_q;
    assign bus.entry_active      = (state_q == StEntry);
    assign bus.commit_ok         = ok_q;
    assign bus.commit_reject     = rej_q;

endmodule

// File: tb/tb_debug_override_entry.sv
// Scoreboard bench for debug_override_entry: directed scenarios plus random key sequences
// checked against a value-level model of the entry rules.
module tb_debug_override_entry;

    localparam int unsigned Deb = 4;
    localparam int unsigned Tmo = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_override_entry_if bus ();

    debug_override_entry #(
        .DEBOUNCE_TICKS(Deb),
        .TIMEOUT_TICKS (Tmo),
        .SPEED_MAX     (100),
        .DIR_MAX       (359)
    ) dut (
        .CLOCK_50   (clk),
        .async_reset(rst_n),
        .bus        (bus)
    );

    typedef struct {
        bit ok;
        int speed;
        bit speed_en;
        int dir;
        bit dir_en;
        bit rev;
        bit rev_en;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_entry;
    int m_acc;
    int m_speed;
    bit m_speed_en;
    int m_dir;
    bit m_dir_en;
    bit m_rev;
    bit m_rev_en;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_entry = 0; m_acc = 0;
        m_speed = 0; m_speed_en = 0;
        m_dir = 0; m_dir_en = 0;
        m_rev = 0; m_rev_en = 0;
    endfunction

    function automatic void model_shift(input int nib);
        if (!m_entry) begin
            if (bus.SW[9]) begin
                m_entry = 1;
                m_acc   = nib;
            end
        end else begin
            m_acc = (m_acc * 16 + nib) % 512;
        end
    endfunction

    function automatic void model_cancel();
        if (m_entry) begin
            m_entry = 0;
            m_acc   = 0;
        end else begin
            m_speed_en = 0; m_dir_en = 0; m_rev_en = 0;
        end
    endfunction

    function automatic void model_abort();
        m_entry = 0;
        m_acc   = 0;
    endfunction

    function automatic void model_commit(input int field);
        exp_t e;
        if (!m_entry) return;
        e.ok = 1;
        case (field)
            0: if (m_acc <= 100) begin m_speed = m_acc; m_speed_en = 1; end else e.ok = 0;
            1: if (m_acc <= 359) begin m_dir = m_acc; m_dir_en = 1; end else e.ok = 0;
            2: begin m_rev = m_acc[0]; m_rev_en = 1; end
            default: begin m_speed_en = 0; m_dir_en = 0; m_rev_en = 0; end
        endcase
        e.speed = m_speed; e.speed_en = m_speed_en;
        e.dir = m_dir; e.dir_en = m_dir_en;
        e.rev = m_rev; e.rev_en = m_rev_en;
        exp_q.push_back(e);
        m_entry = 0;
        m_acc   = 0;
    endfunction

    // Monitor: every commit pulse is matched against the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && (bus.commit_ok || bus.commit_reject)) begin
            check("pulse_exclusive", int'(bus.commit_ok & bus.commit_reject), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_commit_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_ok", int'(bus.commit_ok), int'(mon_e.ok));
                check("commit_reject", int'(bus.commit_reject), int'(!mon_e.ok));
                check("pulse_speed", int'(bus.override_speed), mon_e.speed);
                check("pulse_speed_en", int'(bus.override_speed_en), int'(mon_e.speed_en));
                check("pulse_dir", int'(bus.override_dir), mon_e.dir);
                check("pulse_dir_en", int'(bus.override_dir_en), int'(mon_e.dir_en));
                check("pulse_rev", int'(bus.override_reverse), int'(mon_e.rev));
                check("pulse_rev_en", int'(bus.override_rev_en), int'(mon_e.rev_en));
            end
        end
    end

    task automatic check_outputs(input string tag);
        check({tag, "_entry_active"}, int'(bus.entry_active), int'(m_entry));
        check({tag, "_entry_value"}, int'(bus.entry_value), m_acc);
        check({tag, "_speed"}, int'(bus.override_speed), m_speed);
        check({tag, "_speed_en"}, int'(bus.override_speed_en), int'(m_speed_en));
        check({tag, "_dir"}, int'(bus.override_dir), m_dir);
        check({tag, "_dir_en"}, int'(bus.override_dir_en), int'(m_dir_en));
        check({tag, "_rev"}, int'(bus.override_reverse), int'(m_rev));
        check({tag, "_rev_en"}, int'(bus.override_rev_en), int'(m_rev_en));
    endtask

    // Press the masked keys (active-low) long enough to debounce, then release
    task automatic press(input logic [3:0] mask);
        @(negedge clk);
        bus.KEY = ~mask;
        repeat (Deb + 8) @(negedge clk);
        bus.KEY = 4'hF;
        repeat (Deb + 8) @(negedge clk);
    endtask

    task automatic op_shift(input int nib);
        @(negedge clk);
        bus.SW[3:0] = 4'(nib);
        model_shift(nib);
        press(4'b0010);
    endtask

    task automatic op_commit(input int field);
        @(negedge clk);
        bus.SW[8:7] = 2'(field);
        model_commit(field);
        press(4'b0100);
    endtask

    task automatic op_cancel();
        model_cancel();
        press(4'b0001);
    endtask

    task automatic op_toggle_enable();
        @(negedge clk);
        bus.SW[9] = ~bus.SW[9];
        if (!bus.SW[9]) model_abort();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.SW  = 10'h0;
        bus.KEY = 4'hF;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_commit_ok", int'(bus.commit_ok), 0);
        check("reset_commit_reject", int'(bus.commit_reject), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Speed 0x64 = 100 is the largest legal value
        bus.SW[9] = 1'b1;
        op_shift(6);
        check_outputs("speed_mid");
        op_shift(4);
        op_commit(0);
        check_outputs("speed");

        // Direction 0x168 rejected, 0x167 accepted
        op_shift(1); op_shift(6); op_shift(8);
        check_outputs("dir360_entry");
        op_commit(1);
        check_outputs("dir360");
        op_shift(1); op_shift(6); op_shift(7);
        op_commit(1);
        check_outputs("dir359");

        // Bouncing shift key yields one event
        @(negedge clk);
        bus.SW[3:0] = 4'h5;
        model_shift(5);
        for (int i = 0; i < 10; i++) begin
            bus.KEY[1] = ~bus.KEY[1];
            repeat (2) @(negedge clk);
        end
        bus.KEY[1] = 1'b0;
        repeat (Deb + 10) @(negedge clk);
        bus.KEY[1] = 1'b1;
        repeat (Deb + 8) @(negedge clk);
        check_outputs("bounce");

        // Cancel and commit in the same cycle: cancel wins, no pulse
        op_shift(2);
        model_cancel();
        press(4'b0101);
        check_outputs("priority");

        // Idle timeout discards the entry
        op_shift(3);
        check_outputs("timeout_pre");
        repeat (Tmo + 16) @(negedge clk);
        model_abort();
        check_outputs("timeout");

        // Dropping SW[9] aborts the entry
        op_shift(3);
        op_toggle_enable();
        check_outputs("abort");
        op_toggle_enable();

        // Cancel in idle clears enables but keeps values
        op_cancel();
        check_outputs("idle_cancel");

        // Random key sequences
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 48)      op_shift(int'($urandom_range(0, 15)));
            else if (r < 75) op_commit(int'($urandom_range(0, 3)));
            else if (r < 87) op_cancel();
            else             op_toggle_enable();
            if (n % 10 == 0) check_outputs("random");
        end

        // Reset during entry with overrides set clears everything without a clock edge
        if (!bus.SW[9]) op_toggle_enable();
        op_shift(3); op_shift(2);
        op_commit(0);
        op_shift(2);
        check_outputs("pre_reset");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        check("async_reset_ok", int'(bus.commit_ok), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        op_shift(9);
        op_commit(2);
        check_outputs("post_reset");

        // Drain: every expected commit must have been seen
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
